lz77_stream_encoder: RTL

- Parametrised successor to the sliding-window LZ77 match engine.
- Shifts input symbols into a shiftable CAM dictionary and tracks the surviving match candidates per entry.
- Emits one (match_pos, match_len, next_symbol) token per run.
- Over the fixed-rate original it adds:
  - valid/ready backpressure on input and output;
  - per-entry valid bits, so unwritten entries never match;
  - end-of-stream flush with dictionary clear;
  - a registered token output.
- Sits between the byte source and the Huffman/packing stage.

---
 rtl/lz77_stream_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lz77_stream_encoder.sv
// lz77_stream_encoder: sliding-window LZ77 match engine over a shiftable CAM
// dictionary with valid/ready handshakes, per-entry valid bits, stream flush
// and a registered (match_pos, match_len, next_symbol, last) token output.
module lz77_stream_encoder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DICT_DEPTH     = 512,
  parameter int unsigned DICT_DEPTH_LOG = 9,
  parameter int unsigned MAX_MATCH      = 65,
  parameter int unsigned LEN_WIDTH      = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DICT_DEPTH_LOG-1:0] out_match_pos,
  output logic [LEN_WIDTH-1:0]      out_match_len,
  output logic [DATA_WIDTH-1:0]     out_next_symbol,
  output logic                      out_last
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_MATCH);

  // Dictionary storage: index 0 holds the most recent symbol.
  logic [DATA_WIDTH-1:0]     dict_data [DICT_DEPTH];
  logic [DICT_DEPTH-1:0]     dict_valid;
  // Surviving match candidates of the current run, one per dictionary index.
  logic [DICT_DEPTH-1:0]     cand;
  logic [DICT_DEPTH-1:0]     hit;
  logic [LEN_WIDTH-1:0]      length;
  logic [DICT_DEPTH_LOG-1:0] pos_reg;
  logic [DICT_DEPTH_LOG-1:0] hit_pos;
  logic                      accept;
  logic                      any_hit;
  logic                      extend;
  logic                      emit;

  // Input side may proceed whenever the token register is free or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // CAM compare against the pre-shift dictionary; unwritten entries never hit.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(DICT_DEPTH); i++) begin
      hit[i] = cand[i] & dict_valid[i] & (dict_data[i] == in_data);
    end
  end

  assign any_hit = |hit;

  // Priority encoder: lowest hitting index wins (closest match).
  always_comb begin
    hit_pos = '0;
    for (int i = int'(DICT_DEPTH) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_pos = DICT_DEPTH_LOG'(i);
      end
    end
  end

  // A run keeps growing until a miss, saturation or end of stream.
  assign extend = accept && any_hit && (length < MAX_LEN) && !in_last;
  assign emit   = accept && !extend;

  // Shift accepted symbols into the dictionary data array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DICT_DEPTH); i++) begin
        dict_data[i] <= '0;
      end
    end else if (accept) begin
      dict_data[0] <= in_data;
      for (int i = 1; i < int'(DICT_DEPTH); i++) begin
        dict_data[i] <= dict_data[i-1];
      end
    end
  end

  // Entry valid bits shift with the data; end of stream empties the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dict_valid <= '0;
    end else if (accept) begin
      if (in_last) begin
        dict_valid <= '0;
      end else begin
        dict_valid <= {dict_valid[DICT_DEPTH-2:0], 1'b1};
      end
    end
  end

  // Run tracking: candidate flags, run length and closest match position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand    <= '1;
      length  <= '0;
      pos_reg <= '0;
    end else if (extend) begin
      cand    <= hit;
      length  <= length + LEN_WIDTH'(1);
      pos_reg <= hit_pos;
    end else if (emit) begin
      cand    <= '1;
      length  <= '0;
      pos_reg <= '0;
    end
  end

  // Token register: loads on emit, holds under backpressure, clears when taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_match_pos   <= '0;
      out_match_len   <= '0;
      out_next_symbol <= '0;
      out_last        <= 1'b0;
    end else if (emit) begin
      out_valid       <= 1'b1;
      out_match_pos   <= (length != '0) ? pos_reg : '0;
      out_match_len   <= length;
      out_next_symbol <= in_data;
      out_last        <= in_last;
    end else if (out_ready) begin
      out_valid       <= 1'b0;
    end
  end

endmodule
